prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Registered, parametrised N-to-log2(N) encoder with three arbitration modes: fixed LSB-first, fixed MSB-first, and round-robin.
- Adds a valid/ready output handshake, a one-hot grant output and a rotating priority pointer, none of which the purely combinational encoder has.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request lines; N >= 2; need not be a power of two.
- MODE, 0, 0 = lowest set bit wins, 1 = highest set bit wins, 2 = round-robin. Any other value is an elaboration error.
- OP_SIZE, $clog2(N), derived localparam giving the index width; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable for a.
- a  input  N  request vector.
- in_ready  output  1  combinational: !rst && (!out_valid || out_ready).
- op  output  OP_SIZE  registered encoded index of the granted request.
- onehot  output  N  registered one-hot grant; equals 1<<op when out_valid=1.
- out_valid  output  1  op/onehot hold a valid grant.
- out_ready  input  1  downstream accepts the grant this cycle.

Behaviour:
- Reset (rst=1 at the edge): op=0, onehot=0, out_valid=0, round-robin pointer ptr=0. in_ready=0 while rst=1. Reset wins over every other event.
- Accept: en && in_ready && (a != 0) at the edge. op, onehot and out_valid=1 are registered on that edge, so latency is 1 cycle.
- Empty request: en && in_ready && (a == 0) is not an accept. out_valid becomes 0 if it was 1 and out_ready=1, otherwise it stays 0. op/onehot keep their previous values (don't-care when out_valid=0).
- en=0 with in_ready=1: no accept. A pending grant pops if out_ready=1, then out_valid=0.
- Backpressure: out_valid=1 && out_ready=0 means in_ready=0. op, onehot and ptr are frozen, and a and en are ignored.
- Pop and accept in the same cycle (out_valid=1, out_ready=1, accept condition true): the new grant replaces the old one with no bubble. Full throughput is one grant per cycle.
- MODE 0: grant = lowest index i with a[i]=1.
- MODE 1: grant = highest index i with a[i]=1.
- MODE 2:
  - Scan upward from ptr, wrapping N-1 to 0; the first set bit wins.
  - On accept with grant g: ptr <= (g == N-1) ? 0 : g+1.
  - ptr changes only on accept, never on pop, stall or empty request.
  - ptr is OP_SIZE bits and always stays in 0..N-1, including for non-power-of-two N.
- op is always in 0..N-1. Bits of a above N-1 do not exist.
- Exactly one bit of onehot is set whenever out_valid=1.
- Reset mid-stall: the grant is dropped (out_valid=0) and ptr=0. The next accept after reset scans from index 0.

Test Plan:
- Reset: N=8, any MODE, rst=1 for 2 cycles with a=8'hFF, en=1 -> out_valid=0, op=0, onehot=0, in_ready=0. After rst falls, in_ready=1 and the first accept yields out_valid=1 one cycle later.
- MODE=0, N=8, a=8'b0110_1000, en=1, out_ready=1 -> next cycle op=3, onehot=8'h08, out_valid=1. Then a=0 -> out_valid=0 the following cycle.
- MODE=1, N=8, a=8'b0110_1000 -> op=6, onehot=8'h40. Then a=8'h01 -> op=0, onehot=8'h01.
- MODE=2, N=8, a=8'hFF held, en=1, out_ready=1 for 10 cycles -> op sequence 0,1,2,3,4,5,6,7,0,1. Repeat with N=5 -> 0,1,2,3,4,0,1,...; op never exceeds 4.
- MODE=2 backpressure:
  - Setup: grant op=2 pending, then out_ready=0 for 3 cycles while a changes.
  - Stall response: op=2 stable, in_ready=0, ptr unchanged.
  - Release: out_ready=1 with a=8'b0000_0101 gives op=0 next cycle (scan from ptr=3 wraps to 0), with no bubble.
- MODE=2 wrap and reset: a=8'b1000_0001 alternating grants -> 0,7,0,7. Assert rst while out_valid=1 and out_ready=0 -> out_valid=0. Then a=8'b1000_0001 -> op=0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-LSB, fixed-MSB or round-robin
// arbitration, a one-hot grant and a valid/ready output handshake.
module prio_encoder_rr #(
    parameter  int N       = 8,
    parameter  int MODE    = 0,
    localparam int OP_SIZE = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N-1:0]       a,
    output logic               in_ready,
    output logic [OP_SIZE-1:0] op,
    output logic [N-1:0]       onehot,
    output logic               out_valid,
    input  logic               out_ready
);

    logic               out_valid_q, out_valid_d;
    logic [OP_SIZE-1:0] op_q, op_d;
    logic [N-1:0]       onehot_q, onehot_d;

    logic               accept;
    logic               pop;
    logic [OP_SIZE-1:0] grant;
    logic [N-1:0]       grant_onehot;

    // A stalled grant blocks new requests; a popping grant can be replaced in the same cycle.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = en && in_ready && (|a);
    assign pop      = out_valid_q && out_ready;

    generate
        if (N < 2) begin : g_bad_n
            $error("prio_encoder_rr: N must be at least 2");
        end

        if (MODE == 0) begin : g_lsb
            logic [N-1:0] shifted;

            always_comb begin
                grant   = '0;
                shifted = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    shifted = a >> i;
                    if (shifted[0]) begin
                        grant = OP_SIZE'(i);
                    end
                end
            end
        end else if (MODE == 1) begin : g_msb
            logic [N-1:0] shifted;

            always_comb begin
                grant   = '0;
                shifted = '0;
                for (int i = 0; i < N; i++) begin
                    shifted = a >> i;
                    if (shifted[0]) begin
                        grant = OP_SIZE'(i);
                    end
                end
            end
        end else if (MODE == 2) begin : g_rr
            localparam logic [OP_SIZE:0] N_W = (OP_SIZE + 1)'(N);

            logic [OP_SIZE-1:0] ptr_q, ptr_d;
            logic [N-1:0]       rot;
            logic [N-1:0]       shifted;
            logic [OP_SIZE-1:0] rr_k;
            logic [OP_SIZE:0]   rr_sum;

            // rot[k] is request (ptr + k) mod N, so the lowest set bit of rot is the
            // first request reached when scanning upward from ptr with wrap-around.
            assign rot = N'({a, a} >> ptr_q);

            always_comb begin
                rr_k    = '0;
                shifted = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    shifted = rot >> i;
                    if (shifted[0]) begin
                        rr_k = OP_SIZE'(i);
                    end
                end
            end

            assign rr_sum = {1'b0, ptr_q} + {1'b0, rr_k};
            assign grant  = (rr_sum >= N_W) ? OP_SIZE'(rr_sum - N_W) : OP_SIZE'(rr_sum);
            assign ptr_d  = (grant == OP_SIZE'(N - 1)) ? '0 : grant + OP_SIZE'(1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_q <= '0;
                end else if (accept) begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_bad_mode
            $error("prio_encoder_rr: MODE must be 0, 1 or 2");
            assign grant = '0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign grant_onehot[gi] = (grant == OP_SIZE'(gi));
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        onehot_d    = onehot_q;
        if (accept) begin
            out_valid_d = 1'b1;
            op_d        = grant;
            onehot_d    = grant_onehot;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            onehot_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            onehot_q    <= onehot_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;
    assign onehot    = onehot_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: four instances (LSB, MSB, RR N=8, RR N=5) share one stimulus
// stream and are checked every cycle against a behavioural model plus directed literals.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;

    always #5 clk = ~clk;

    logic [2:0] op0, op1, op2, op3;
    logic [7:0] oh0, oh1, oh2;
    logic [4:0] oh3;
    logic       v0, v1, v2, v3;
    logic       ir0, ir1, ir2, ir3;

    logic [2:0] op_w [4];
    logic [7:0] oh_w [4];
    logic       v_w  [4];
    logic       ir_w [4];

    assign op_w[0] = op0;  assign op_w[1] = op1;  assign op_w[2] = op2;  assign op_w[3] = op3;
    assign oh_w[0] = oh0;  assign oh_w[1] = oh1;  assign oh_w[2] = oh2;  assign oh_w[3] = {3'b000, oh3};
    assign v_w[0]  = v0;   assign v_w[1]  = v1;   assign v_w[2]  = v2;   assign v_w[3]  = v3;
    assign ir_w[0] = ir0;  assign ir_w[1] = ir1;  assign ir_w[2] = ir2;  assign ir_w[3] = ir3;

    prio_encoder_rr #(.N(8), .MODE(0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .a(a), .in_ready(ir0), .op(op0),
        .onehot(oh0), .out_valid(v0), .out_ready(out_ready));
    prio_encoder_rr #(.N(8), .MODE(1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .a(a), .in_ready(ir1), .op(op1),
        .onehot(oh1), .out_valid(v1), .out_ready(out_ready));
    prio_encoder_rr #(.N(8), .MODE(2)) u_rr8 (
        .clk(clk), .rst(rst), .en(en), .a(a), .in_ready(ir2), .op(op2),
        .onehot(oh2), .out_valid(v2), .out_ready(out_ready));
    prio_encoder_rr #(.N(5), .MODE(2)) u_rr5 (
        .clk(clk), .rst(rst), .en(en), .a(a[4:0]), .in_ready(ir3), .op(op3),
        .onehot(oh3), .out_valid(v3), .out_ready(out_ready));

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state per instance
    int         m_mode [4] = '{0, 1, 2, 2};
    int         m_n    [4] = '{8, 8, 8, 5};
    logic       m_v    [4];
    int         m_op   [4];
    logic [7:0] m_oh   [4];
    int         m_ptr  [4];

    function automatic int ref_grant(int mode, int n, int ptr, logic [7:0] req);
        int g = -1;
        if (mode == 0) begin
            for (int i = 0; i < n; i++)
                if (g < 0 && req[i[2:0]]) g = i;
        end else if (mode == 1) begin
            for (int i = n - 1; i >= 0; i--)
                if (g < 0 && req[i[2:0]]) g = i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int idx = (ptr + k) % n;
                if (g < 0 && req[idx[2:0]]) g = idx;
            end
        end
        return g;
    endfunction

    // Grant the instance would take at this edge, or -1 if nothing is accepted.
    function automatic int acc_grant(int j);
        logic [7:0] req;
        if (!en || !(!m_v[j] || out_ready)) return -1;
        req = a & 8'((1 << m_n[j]) - 1);
        return ref_grant(m_mode[j], m_n[j], m_ptr[j], req);
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (rst) begin
                m_v[j]   <= 1'b0;
                m_op[j]  <= 0;
                m_oh[j]  <= 8'h00;
                m_ptr[j] <= 0;
            end else if (acc_grant(j) >= 0) begin
                m_v[j]  <= 1'b1;
                m_op[j] <= acc_grant(j);
                m_oh[j] <= 8'(1) << acc_grant(j);
                if (m_mode[j] == 2) m_ptr[j] <= (acc_grant(j) + 1) % m_n[j];
                $display("inst%0d accept a=%02h grant=%0d", j, a, acc_grant(j));
            end else if (m_v[j] && out_ready) begin
                m_v[j] <= 1'b0;
            end
        end
    end

    // Compare process: every negedge, all instances against the model.
    initial begin
        wait (cmp_on);
        forever begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("inst%0d_valid", j), 32'(v_w[j]), 32'(m_v[j]));
                chk($sformatf("inst%0d_op", j), 32'(op_w[j]), 32'(m_op[j]));
                chk($sformatf("inst%0d_onehot", j), 32'(oh_w[j]), 32'(m_oh[j]));
                chk($sformatf("inst%0d_in_ready", j), 32'(ir_w[j]),
                    32'(!rst && (!m_v[j] || out_ready)));
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [7:0] av, input logic rd);
        rst = r; en = e; a = av; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         exp8 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        int         exp5 [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        logic [7:0] stall_a [3] = '{8'h10, 8'h01, 8'hF0};
        int         exp_wrap [3] = '{7, 0, 7};
        logic       r, e, rd;
        logic [7:0] av;

        // Reset with requests present
        cyc(1, 1, 8'hFF, 1);
        cmp_on = 1'b1;
        cyc(1, 1, 8'hFF, 1);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_op", 32'(op0), 0);
        chk("rst_onehot", 32'(oh0), 0);
        chk("rst_in_ready", 32'(ir0), 0);

        // Fixed priorities
        cyc(0, 1, 8'b0110_1000, 1);
        chk("lsb_op", 32'(op0), 3);
        chk("lsb_onehot", 32'(oh0), 32'h08);
        chk("lsb_valid", 32'(v0), 1);
        chk("msb_op", 32'(op1), 6);
        chk("msb_onehot", 32'(oh1), 32'h40);
        chk("model_rr5_ptr", 32'(m_ptr[3]), 4);
        cyc(0, 1, 8'h01, 1);
        chk("msb_op_b0", 32'(op1), 0);
        chk("msb_onehot_b0", 32'(oh1), 32'h01);
        chk("rr8_wrap_from4", 32'(op2), 0);
        chk("rr5_wrap_from4", 32'(op3), 0);
        cyc(0, 1, 8'h00, 1);
        chk("lsb_empty_valid", 32'(v0), 0);

        // Round-robin rotation, N=8 and N=5
        cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 8'hFF, 1);
            chk($sformatf("rr8_seq%0d", i), 32'(op2), 32'(exp8[i]));
            chk($sformatf("rr5_seq%0d", i), 32'(op3), 32'(exp5[i]));
        end

        // Backpressure on a pending grant of 2
        cyc(0, 1, 8'hFF, 1);
        chk("rr8_bp_setup", 32'(op2), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, stall_a[i], 0);
            chk($sformatf("rr8_stall_op%0d", i), 32'(op2), 2);
            chk($sformatf("rr8_stall_valid%0d", i), 32'(v2), 1);
            chk($sformatf("rr8_stall_ready%0d", i), 32'(ir2), 0);
        end
        cyc(0, 1, 8'b0000_0101, 1);
        chk("rr8_release_op", 32'(op2), 0);
        chk("rr8_release_valid", 32'(v2), 1);

        // Alternating wrap, then reset mid-stall
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'b1000_0001, 1);
            chk($sformatf("rr8_alt%0d", i), 32'(op2), 32'(exp_wrap[i]));
        end
        cyc(0, 1, 8'b1000_0001, 1);
        chk("rr8_alt_back0", 32'(op2), 0);
        cyc(0, 1, 8'b1000_0001, 0);
        chk("rr8_hold_valid", 32'(v2), 1);
        cyc(1, 1, 8'b1000_0001, 0);
        chk("rr8_rst_stall_valid", 32'(v2), 0);
        cyc(0, 1, 8'b1000_0001, 1);
        chk("rr8_after_rst_op", 32'(op2), 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 85);
            rd = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 3))
                0:       av = 8'h00;
                1:       av = 8'(1) << $urandom_range(0, 7);
                default: av = 8'($urandom);
            endcase
            cyc(r, e, av, rd);
        end
        cyc(0, 0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
